// File: rtl/rpc_wmask_gen.sv
// rtl/rpc_wmask_gen.sv - DRAM write-mask generator for RPC write commands
//
// Captures first/last beat strobes of each W burst into a small FIFO and,
// on every accepted write command (or split half), presents the 2-word
// DRAM mask for that command one cycle later.
//
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   w_valid_i, w_ready_i              W handshake (observed only)
//   w_last_i, w_strb_i                last-beat flag and beat strobes
//   w_full_o                          burst FIFO full
//   cmd_valid_i, cmd_ready_i          command handshake (observed only)
//   cmd_write_i, cmd_split_i          write flag, split code (0/1/2/3)
//   cmd_len_i                         beats-1 of the command
//   mask_o, mask_valid_o              registered DRAM mask and its valid
//   usage_o                           stored burst entries
//   err_mid_partial_o                 one-cycle pulse: partial middle beat
//   err_overflow_o, err_underflow_o,
//   err_seq_o                         sticky error flags

module rpc_wmask_gen #(
  parameter int unsigned StrbWidth = 32,
  parameter int unsigned BufDepth  = 4,
  parameter int unsigned LenWidth  = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           w_valid_i,
  input  logic                           w_ready_i,
  input  logic                           w_last_i,
  input  logic [StrbWidth-1:0]           w_strb_i,
  output logic                           w_full_o,
  input  logic                           cmd_valid_i,
  input  logic                           cmd_ready_i,
  input  logic                           cmd_write_i,
  input  logic [1:0]                     cmd_split_i,
  input  logic [LenWidth-1:0]            cmd_len_i,
  output logic [2*StrbWidth-1:0]         mask_o,
  output logic                           mask_valid_o,
  output logic [$clog2(BufDepth+1)-1:0]  usage_o,
  output logic                           err_mid_partial_o,
  output logic                           err_overflow_o,
  output logic                           err_underflow_o,
  output logic                           err_seq_o
);

  localparam int unsigned UsageW = $clog2(BufDepth + 1);
  localparam int unsigned PtrW   = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam logic [PtrW-1:0]      PtrLast   = PtrW'(BufDepth - 1);
  localparam logic [UsageW-1:0]    UsageFull = UsageW'(BufDepth);
  localparam logic [StrbWidth-1:0] Ones      = '1;

  logic [2*StrbWidth-1:0] mem_q [BufDepth];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [UsageW-1:0]      usage_q, usage_d;
  logic                   first_q;
  logic [StrbWidth-1:0]   first_mask_q;
  logic [StrbWidth-1:0]   held_l_q, held_l_d;
  logic [LenWidth-1:0]    len_q, len_d;
  logic                   pending_q, pending_d;
  logic [2*StrbWidth-1:0] mask_q, mask_d;
  logic                   mask_valid_q, mask_valid_d;
  logic                   mid_q, ovf_q, udf_q, seq_q;

  logic w_hs, push_req, wcmd_hs, pop_req, empty, full, push, pop;
  logic seq_evt, mid_evt;
  logic [2*StrbWidth-1:0] push_entry, rd_entry;
  logic [StrbWidth-1:0]   pop_f, pop_l;

  assign w_hs     = w_valid_i & w_ready_i;
  assign push_req = w_hs & w_last_i;
  assign wcmd_hs  = cmd_valid_i & cmd_ready_i & cmd_write_i;
  assign pop_req  = wcmd_hs & ~cmd_split_i[1];
  assign empty    = (usage_q == '0);
  assign full     = (usage_q == UsageFull);
  // No fall-through: a pop only sees entries stored before this cycle.
  assign pop      = pop_req & ~empty;
  // When full, a simultaneous pop frees a slot, so the push is a legal swap.
  assign push     = push_req & (~full | pop);
  assign mid_evt  = w_hs & ~first_q & ~w_last_i & (w_strb_i != Ones);

  // Single-beat bursts use the current strobe for both fields.
  assign push_entry = {(first_q ? w_strb_i : first_mask_q), w_strb_i};
  assign rd_entry   = mem_q[rd_ptr_q];
  assign pop_f      = rd_entry[2*StrbWidth-1:StrbWidth];
  assign pop_l      = rd_entry[StrbWidth-1:0];

  always_comb begin
    usage_d = usage_q;
    if (push && !pop)      usage_d = usage_q + UsageW'(1);
    else if (pop && !push) usage_d = usage_q - UsageW'(1);
  end

  always_comb begin
    mask_d       = mask_q;
    mask_valid_d = mask_valid_q;
    held_l_d     = held_l_q;
    len_d        = len_q;
    pending_d    = pending_q;
    seq_evt      = 1'b0;
    if (wcmd_hs) begin
      case (cmd_split_i)
        2'd0, 2'd1: begin
          seq_evt   = pending_q;
          pending_d = cmd_split_i[0];
          if (empty) begin
            mask_d       = '0;
            mask_valid_d = 1'b0;
          end else begin
            held_l_d     = pop_l;
            len_d        = cmd_len_i;
            mask_valid_d = 1'b1;
            if (cmd_split_i[0])
              mask_d = {pop_f, ((cmd_len_i == '0) ? pop_f : Ones)};
            else
              mask_d = {pop_f, pop_l};
          end
        end
        2'd2: begin
          if (pending_q) begin
            pending_d    = 1'b0;
            mask_d       = {((len_q == '0) ? held_l_q : Ones), held_l_q};
            mask_valid_d = 1'b1;
          end else begin
            seq_evt      = 1'b1;
            mask_d       = '0;
            mask_valid_d = 1'b0;
          end
        end
        default: begin
          seq_evt      = 1'b1;
          mask_d       = '0;
          mask_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Entry storage needs no reset: usage and pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      usage_q      <= '0;
      first_q      <= 1'b1;
      first_mask_q <= '0;
      held_l_q     <= '0;
      len_q        <= '0;
      pending_q    <= 1'b0;
      mask_q       <= '0;
      mask_valid_q <= 1'b0;
      mid_q        <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      seq_q        <= 1'b0;
    end else begin
      if (w_hs) first_q <= w_last_i;
      if (w_hs && first_q) first_mask_q <= w_strb_i;
      if (push) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
      usage_q      <= usage_d;
      held_l_q     <= held_l_d;
      len_q        <= len_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      mask_valid_q <= mask_valid_d;
      mid_q        <= mid_evt;
      ovf_q        <= ovf_q | (push_req & ~push);
      udf_q        <= udf_q | (pop_req & empty);
      seq_q        <= seq_q | seq_evt;
    end
  end

  assign w_full_o          = full;
  assign usage_o           = usage_q;
  assign mask_o            = mask_q;
  assign mask_valid_o      = mask_valid_q;
  assign err_mid_partial_o = mid_q;
  assign err_overflow_o    = ovf_q;
  assign err_underflow_o   = udf_q;
  assign err_seq_o         = seq_q;

endmodule

// File: tb/tb_rpc_wmask_gen.sv
// tb/tb_rpc_wmask_gen.sv - directed self-checking bench for rpc_wmask_gen

module tb_rpc_wmask_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        w_valid_i = 1'b0, w_ready_i = 1'b0, w_last_i = 1'b0;
  logic [31:0] w_strb_i = '0;
  logic        w_full_o;
  logic        cmd_valid_i = 1'b0, cmd_ready_i = 1'b0, cmd_write_i = 1'b0;
  logic [1:0]  cmd_split_i = '0;
  logic [5:0]  cmd_len_i = '0;
  logic [63:0] mask_o;
  logic        mask_valid_o;
  logic [2:0]  usage_o;
  logic        err_mid_partial_o, err_overflow_o, err_underflow_o, err_seq_o;

  int n_checks = 0;
  int n_fail   = 0;

  rpc_wmask_gen #(.StrbWidth(32), .BufDepth(4), .LenWidth(6)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .w_last_i(w_last_i),
    .w_strb_i(w_strb_i), .w_full_o(w_full_o),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_i(cmd_ready_i),
    .cmd_write_i(cmd_write_i), .cmd_split_i(cmd_split_i), .cmd_len_i(cmd_len_i),
    .mask_o(mask_o), .mask_valid_o(mask_valid_o), .usage_o(usage_o),
    .err_mid_partial_o(err_mid_partial_o), .err_overflow_o(err_overflow_o),
    .err_underflow_o(err_underflow_o), .err_seq_o(err_seq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_w(input logic [31:0] strb, input logic last);
    w_valid_i = 1'b1; w_ready_i = 1'b1; w_last_i = last; w_strb_i = strb;
  endtask

  task automatic set_cmd(input logic [1:0] split, input logic [5:0] len);
    cmd_valid_i = 1'b1; cmd_ready_i = 1'b1; cmd_write_i = 1'b1;
    cmd_split_i = split; cmd_len_i = len;
  endtask

  // Advance one edge, then release all handshakes; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk_i);
    #1;
    w_valid_i = 1'b0; w_ready_i = 1'b0; w_last_i = 1'b0; w_strb_i = '0;
    cmd_valid_i = 1'b0; cmd_ready_i = 1'b0; cmd_write_i = 1'b0;
    cmd_split_i = '0; cmd_len_i = '0;
  endtask

  task automatic beat(input logic [31:0] strb, input logic last);
    set_w(strb, last);
    step();
  endtask

  task automatic wcmd(input logic [1:0] split, input logic [5:0] len);
    set_cmd(split, len);
    step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mask"}, mask_o, 64'h0);
    check({tag, "_valid"}, {63'h0, mask_valid_o}, 64'h0);
    check({tag, "_usage"}, {61'h0, usage_o}, 64'h0);
    check({tag, "_full"}, {63'h0, w_full_o}, 64'h0);
    check({tag, "_errs"}, {60'h0, err_mid_partial_o, err_overflow_o, err_underflow_o, err_seq_o}, 64'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_state("rst");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single-beat burst, unsplit command
    beat(32'h0000_FFFF, 1'b1);
    check("t1_usage_push", {61'h0, usage_o}, 64'd1);
    wcmd(2'd0, 6'd0);
    check("t1_mask", mask_o, 64'h0000_FFFF_0000_FFFF);
    check("t1_valid", {63'h0, mask_valid_o}, 64'd1);
    check("t1_usage_pop", {61'h0, usage_o}, 64'd0);

    // 4-beat burst, split 1/2 with len=3
    beat(32'hFFFF_FFF0, 1'b0);
    beat(32'hFFFF_FFFF, 1'b0);
    check("t2_no_mid", {63'h0, err_mid_partial_o}, 64'd0);
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'h0FFF_FFFF, 1'b1);
    wcmd(2'd1, 6'd3);
    check("t2_mask_s1", mask_o, 64'hFFFF_FFF0_FFFF_FFFF);
    wcmd(2'd2, 6'd3);
    check("t2_mask_s2", mask_o, 64'hFFFF_FFFF_0FFF_FFFF);
    check("t2_valid", {63'h0, mask_valid_o}, 64'd1);

    // Split 1/2 with len=0
    beat(32'h00FF_00FF, 1'b0);
    beat(32'hF0F0_F0F0, 1'b1);
    wcmd(2'd1, 6'd0);
    check("t3_mask_s1", mask_o, 64'h00FF_00FF_00FF_00FF);
    wcmd(2'd2, 6'd0);
    check("t3_mask_s2", mask_o, 64'hF0F0_F0F0_F0F0_F0F0);
    check("t3_no_errs", {60'h0, err_mid_partial_o, err_overflow_o, err_underflow_o, err_seq_o}, 64'h0);

    // Fill to full, then one extra push is dropped
    for (int i = 1; i <= 4; i++) beat(32'h1111_1111 * i, 1'b1);
    check("t4_full", {63'h0, w_full_o}, 64'd1);
    check("t4_usage_full", {61'h0, usage_o}, 64'd4);
    check("t4_no_ovf_yet", {63'h0, err_overflow_o}, 64'd0);
    beat(32'h5555_5555, 1'b1);
    check("t4_ovf", {63'h0, err_overflow_o}, 64'd1);
    check("t4_usage_after_ovf", {61'h0, usage_o}, 64'd4);
    // Swap while full: pop entry 1, push 0xAAAA_AAAA
    set_w(32'hAAAA_AAAA, 1'b1);
    set_cmd(2'd0, 6'd0);
    step();
    check("t4_swap_mask", mask_o, 64'h1111_1111_1111_1111);
    check("t4_swap_usage", {61'h0, usage_o}, 64'd4);
    check("t4_swap_no_udf", {63'h0, err_underflow_o}, 64'd0);
    wcmd(2'd0, 6'd0);
    check("t4_pop2", mask_o, 64'h2222_2222_2222_2222);
    wcmd(2'd0, 6'd0);
    check("t4_pop3", mask_o, 64'h3333_3333_3333_3333);
    wcmd(2'd0, 6'd0);
    check("t4_pop4", mask_o, 64'h4444_4444_4444_4444);
    wcmd(2'd0, 6'd0);
    check("t4_pop_swapped", mask_o, 64'hAAAA_AAAA_AAAA_AAAA);
    check("t4_drained", {61'h0, usage_o}, 64'd0);

    // Pop on empty with simultaneous last beat: underflow, entry still stored
    set_w(32'h1234_5678, 1'b1);
    set_cmd(2'd0, 6'd0);
    step();
    check("t5_udf", {63'h0, err_underflow_o}, 64'd1);
    check("t5_valid", {63'h0, mask_valid_o}, 64'd0);
    check("t5_mask", mask_o, 64'h0);
    check("t5_usage", {61'h0, usage_o}, 64'd1);
    wcmd(2'd0, 6'd0);
    check("t5_pop_mask", mask_o, 64'h1234_5678_1234_5678);
    check("t5_pop_valid", {63'h0, mask_valid_o}, 64'd1);

    // Read command leaves mask untouched
    cmd_valid_i = 1'b1; cmd_ready_i = 1'b1; cmd_write_i = 1'b0;
    step();
    check("t6_read_hold", mask_o, 64'h1234_5678_1234_5678);

    // Orphan split 2
    check("t6_no_seq", {63'h0, err_seq_o}, 64'd0);
    wcmd(2'd2, 6'd0);
    check("t6_seq", {63'h0, err_seq_o}, 64'd1);
    check("t6_seq_mask", mask_o, 64'h0);
    check("t6_seq_valid", {63'h0, mask_valid_o}, 64'd0);

    // Partial middle beat pulse, then reset mid-burst
    beat(32'hDEAD_BEEF, 1'b1);
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'hFFFF_FFFE, 1'b0);
    check("t7_mid_pulse", {63'h0, err_mid_partial_o}, 64'd1);
    beat(32'hFFFF_FFFF, 1'b0);
    check("t7_mid_clear", {63'h0, err_mid_partial_o}, 64'd0);
    check("t7_usage_pre_rst", {61'h0, usage_o}, 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_state("t7_async_rst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // First flag must be back to 1: single beat uses its own strobe for F
    beat(32'hCAFE_F00D, 1'b1);
    wcmd(2'd0, 6'd0);
    check("t8_post_rst_mask", mask_o, 64'hCAFE_F00D_CAFE_F00D);
    check("t8_post_rst_usage", {61'h0, usage_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
